exc_ctrl: RTL
=============

# exc_ctrl

Exception control unit for the single-cycle LEGv8 core with exceptions. It consumes the main decoder's exception outputs (`EStatus`, `ERet`) and the external interrupt line, and decides when an exception is taken. It holds the architectural exception registers (ELR, ESR) and a saturating taken-exception counter, exposes them to MRS reads, and drives the next-PC select mux in the fetch stage. Its state machine masks interrupts inside a handler, returns on ERET, and halts on a double fault.

## Interface
- `N`, 64: datapath / register width.
- `VECTOR`, 64'h0000_0000_0000_00D8: exception vector address.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `PC`  in  N  address of the instruction executing this cycle.
- `EStatus`  in  4  decoder cause; non-zero = synchronous fault (0010 = invalid opcode).
- `ERet`  in  1  decoder: current instruction is ERET.
- `ExtIRQ`  in  1  level external interrupt request; held high until acknowledged.
- `SysSel`  in  2  MRS source select: 00 ELR, 01 ESR, 10 count, 11 zero.
- `NextPCSel`  out  2  00 PC+4, 01 `VECTOR`, 10 ELR, 11 hold PC.
- `ExcVector`  out  N  constant `VECTOR`.
- `ELR`  out  N  exception link register.
- `ESR`  out  N  exception syndrome register, `{N-4 zeros, cause}`.
- `SysRdData`  out  N  MRS read data per `SysSel`.
- `ExtIAck`  out  1  one-cycle interrupt acknowledge.
- `InHandler`  out  1  high in HANDLER state.
- `Fault`  out  1  high in FAULT state.

## Operation
- States: RUN, HANDLER, FAULT. Reset state RUN.
- Definitions: `sync = (EStatus != 0)`; `irq = ExtIRQ && state==RUN`.
- RUN:
  - `sync`: NextPCSel=01. At the edge: ELR←PC+4, ESR←EStatus, count+1, go HANDLER. `sync` has priority over a simultaneous `irq`; the IRQ stays pending because it is level-held.
  - else `irq`: NextPCSel=01. At the edge: ELR←PC+4, ESR cause←4'b0001, count+1, ExtIAck←1, go HANDLER.
  - else `ERet`: ignored. NextPCSel=00, no state change.
  - else NextPCSel=00.
- HANDLER:
  - ExtIRQ is masked: no take, no ack.
  - `sync`: double fault. NextPCSel=11. At the edge: ESR←EStatus, go FAULT. ELR keeps its value and the count is unchanged.
  - else `ERet`: NextPCSel=10. At the edge, go RUN. A pending IRQ may be taken in the following cycle.
  - else NextPCSel=00.
- FAULT: NextPCSel=11 permanently. All inputs are ignored. Only reset exits this state.
- Arithmetic and width rules:
  - PC+4 is computed modulo 2^N, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - The count is 8 bits and saturates at 8'hFF.
  - `SysRdData` for SysSel=10 is `{N-8 zeros, count}`.
- `SysRdData`, `NextPCSel`, `ExcVector`, `InHandler` and `Fault` are combinational from the current state, registers and inputs.
- ExtIAck is a registered output. It is high for exactly the one cycle following an IRQ take and cannot assert in consecutive cycles.

## Timing
- Reset (asynchronous, active-low) forces: state=RUN, ELR=0, ESR=0, count=0, ExtIAck=0. Resulting outputs: InHandler=0, Fault=0. NextPCSel=00 while reset is asserted.
- Reset in the middle of a handler or in FAULT takes effect immediately and returns the block to RUN.
- Redirect latency is zero: NextPCSel reacts in the same cycle as the cause. The handler's first instruction is fetched at the next edge.
- ELR, ESR and the count are visible on `SysRdData` from the cycle after the take. An MRS in the handler's first instruction reads the new values.
- IRQ handshake: the device must keep ExtIRQ high until it samples ExtIAck=1, then drop it. If ExtIRQ is still high after an ERET, a second interrupt is taken in the first RUN cycle.
- ERet and `sync` in the same HANDLER cycle: `sync` wins and the block goes to FAULT.

## Test plan
- Invalid opcode in RUN: PC=0x40, EStatus=0010 → that cycle NextPCSel=01. Next cycle ELR=0x44, ESR=0x2, InHandler=1, count=1, ExtIAck=0.
- IRQ take and return: ExtIRQ=1 at PC=0x100 → NextPCSel=01, then ExtIAck=1 for one cycle and ELR=0x104, ESR=0x1. Drop ExtIRQ, then ERet=1 → NextPCSel=10, state RUN.
- Masking and pending: ExtIRQ=1 while in HANDLER for 5 cycles → no ack, NextPCSel=00. ERet → RUN, then IRQ taken the next cycle with count incremented.
- Simultaneous sync+IRQ in RUN: EStatus=0010 and ExtIRQ=1 → ESR=0x2 and no ack. After ERET the IRQ is taken with ESR=0x1.
- Double fault: EStatus=0010 in HANDLER → NextPCSel=11, Fault=1, ELR unchanged. ERet and ExtIRQ are then ignored. Asserting reset low mid-cycle clears to RUN with ELR=ESR=count=0.
- Wrap and saturation: PC=64'hFFFF_FFFF_FFFF_FFFC fault → ELR=0. 300 take/return cycles → SysSel=10 reads 0xFF.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception control for the single-cycle LEGv8 core: takes sync faults and
// external IRQs, holds ELR/ESR/count, steers the next-PC mux, halts on double fault.
module exc_ctrl #(
  parameter int             N      = 64,
  parameter logic [N-1:0]   VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PC,
  input  logic [3:0]   EStatus,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [1:0]   SysSel,
  output logic [1:0]   NextPCSel,
  output logic [N-1:0] ExcVector,
  output logic [N-1:0] ELR,
  output logic [N-1:0] ESR,
  output logic [N-1:0] SysRdData,
  output logic         ExtIAck,
  output logic         InHandler,
  output logic         Fault
);

  typedef enum logic [1:0] {RUN, HANDLER, FAULT} state_t;

  state_t       state_q;
  logic [N-1:0] elr_q;
  logic [3:0]   esr_q;
  logic [7:0]   cnt_q;
  logic         ack_q;

  logic         sync, take_sync, take_irq;
  logic [N-1:0] pc_plus4;
  logic [7:0]   cnt_inc;

  assign sync      = (EStatus != 4'd0);
  assign take_sync = (state_q == RUN) && sync;
  // sync wins over a simultaneous IRQ; the level-held IRQ is taken later
  assign take_irq  = (state_q == RUN) && !sync && ExtIRQ;
  assign pc_plus4  = PC + N'(4);
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      elr_q   <= '0;
      esr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (take_sync || take_irq) begin
            elr_q   <= pc_plus4;
            esr_q   <= take_sync ? EStatus : 4'b0001;
            cnt_q   <= cnt_inc;
            ack_q   <= take_irq;
            state_q <= HANDLER;
          end
        end
        HANDLER: begin
          if (sync) begin
            esr_q   <= EStatus;
            state_q <= FAULT;
          end else if (ERet) begin
            state_q <= RUN;
          end
        end
        default: state_q <= FAULT;
      endcase
    end
  end

  always_comb begin
    NextPCSel = 2'b00;
    if (reset) begin
      case (state_q)
        RUN:     NextPCSel = (take_sync || take_irq) ? 2'b01 : 2'b00;
        HANDLER: NextPCSel = sync ? 2'b11 : (ERet ? 2'b10 : 2'b00);
        default: NextPCSel = 2'b11;
      endcase
    end
  end

  always_comb begin
    SysRdData = '0;
    case (SysSel)
      2'b00:   SysRdData = elr_q;
      2'b01:   SysRdData = ESR;
      2'b10:   SysRdData = {{(N-8){1'b0}}, cnt_q};
      default: SysRdData = '0;
    endcase
  end

  assign ExcVector = VECTOR;
  assign ELR       = elr_q;
  assign ESR       = {{(N-4){1'b0}}, esr_q};
  assign ExtIAck   = ack_q;
  assign InHandler = (state_q == HANDLER);
  assign Fault     = (state_q == FAULT);

endmodule
